// File: rtl/circle_sequencer_if.sv
// Handshake and pixel bus between the ring sequencer and the circle drawer.
// The sequencer (master) hands out one circle at a time and forwards the
// pixels the drawer (slave) produces for that circle.
interface circle_sequencer_if;
    logic [7:0] centerx;
    logic [7:0] centery;
    logic [7:0] radius;
    logic       draw_start;
    logic       draw_done;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic       draw_plot;

    modport master (
        output centerx, centery, radius, draw_start,
        input  draw_done, draw_x, draw_y, draw_plot
    );

    modport slave (
        input  centerx, centery, radius, draw_start,
        output draw_done, draw_x, draw_y, draw_plot
    );
endinterface

// File: rtl/circle_sequencer.sv
// Concentric ring sequencer: clears the screen to BLACK one pixel per cycle,
// then launches the circle drawer once per ring with a growing radius,
// forwarding (and clipping) the drawer's pixels to the VGA adapter.
// All outputs are registered. A ring whose radius would exceed 255 ends the
// sequence early without being issued.
module circle_sequencer #(
    parameter int         SCREEN_WIDTH  = 160,
    parameter int         SCREEN_HEIGHT = 120,
    parameter logic [2:0] BLACK         = 3'b000
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                cx,
    input  logic [7:0]                cy,
    input  logic [7:0]                r_base,
    input  logic [7:0]                r_step,
    input  logic [2:0]                ring_count,
    input  logic [2:0]                ring_colour,
    circle_sequencer_if.master        drw,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic                      plot,
    output logic [2:0]                colour,
    output logic                      busy,
    output logic                      done
);

    localparam logic [7:0] X_LAST  = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0] Y_LAST  = 7'(SCREEN_HEIGHT - 1);
    localparam logic [8:0] X_LIMIT = 9'(SCREEN_WIDTH);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_HEIGHT);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, FINISH} state_t;

    state_t     state, state_n;

    // Latched request parameters. The radius accumulator holds the radius of
    // the next ring; it is only advanced after a ring that fitted in 8 bits,
    // so 9 bits are always enough to see the overflow.
    logic [7:0] r_step_q, r_step_n;
    logic [2:0] ring_count_q, ring_count_n;
    logic [2:0] ring_colour_q, ring_colour_n;
    logic [8:0] radius_acc, radius_acc_n;
    logic [2:0] k, k_n;

    logic [7:0] x_n;
    logic [6:0] y_n;
    logic       plot_n;
    logic [2:0] colour_n;
    logic       busy_n;
    logic       done_n;
    logic [7:0] centerx_n;
    logic [7:0] centery_n;
    logic [7:0] radius_n;
    logic       draw_start_n;
    logic       on_screen;

    assign on_screen = ({1'b0, drw.draw_x} < X_LIMIT) && ({1'b0, drw.draw_y} < Y_LIMIT);

    // State, latched parameters and all outputs update together on the clock.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= IDLE;
            r_step_q       <= 8'd0;
            ring_count_q   <= 3'd0;
            ring_colour_q  <= 3'd0;
            radius_acc     <= 9'd0;
            k              <= 3'd0;
            x              <= 8'd0;
            y              <= 7'd0;
            plot           <= 1'b0;
            colour         <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            drw.centerx    <= 8'd0;
            drw.centery    <= 8'd0;
            drw.radius     <= 8'd0;
            drw.draw_start <= 1'b0;
        end else begin
            state          <= state_n;
            r_step_q       <= r_step_n;
            ring_count_q   <= ring_count_n;
            ring_colour_q  <= ring_colour_n;
            radius_acc     <= radius_acc_n;
            k              <= k_n;
            x              <= x_n;
            y              <= y_n;
            plot           <= plot_n;
            colour         <= colour_n;
            busy           <= busy_n;
            done           <= done_n;
            drw.centerx    <= centerx_n;
            drw.centery    <= centery_n;
            drw.radius     <= radius_n;
            drw.draw_start <= draw_start_n;
        end
    end

    // Next-state and next-output logic; values hold unless a state changes them.
    always_comb begin
        state_n       = state;
        r_step_n      = r_step_q;
        ring_count_n  = ring_count_q;
        ring_colour_n = ring_colour_q;
        radius_acc_n  = radius_acc;
        k_n           = k;
        x_n           = x;
        y_n           = y;
        plot_n        = 1'b0;
        colour_n      = colour;
        busy_n        = busy;
        done_n        = done;
        centerx_n     = drw.centerx;
        centery_n     = drw.centery;
        radius_n      = drw.radius;
        draw_start_n  = 1'b0;

        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    centerx_n     = cx;
                    centery_n     = cy;
                    r_step_n      = r_step;
                    ring_count_n  = ring_count;
                    ring_colour_n = ring_colour;
                    radius_acc_n  = {1'b0, r_base};
                    k_n           = 3'd0;
                    x_n           = 8'd0;
                    y_n           = 7'd0;
                    plot_n        = 1'b1;
                    colour_n      = BLACK;
                    busy_n        = 1'b1;
                    done_n        = 1'b0;
                    state_n       = CLEAR;
                end
            end

            CLEAR: begin
                if (x == X_LAST) begin
                    x_n = 8'd0;
                    if (y == Y_LAST) begin
                        state_n = ISSUE;
                    end else begin
                        y_n    = y + 7'd1;
                        plot_n = 1'b1;
                    end
                end else begin
                    x_n    = x + 8'd1;
                    plot_n = 1'b1;
                end
            end

            ISSUE: begin
                if ((k == ring_count_q) || radius_acc[8]) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    radius_n     = radius_acc[7:0];
                    draw_start_n = 1'b1;
                    colour_n     = ring_colour_q;
                    state_n      = WAIT;
                end
            end

            WAIT: begin
                if (drw.draw_done) begin
                    k_n          = k + 3'd1;
                    radius_acc_n = radius_acc + {1'b0, r_step_q};
                    state_n      = ISSUE;
                end else begin
                    x_n      = drw.draw_x;
                    y_n      = drw.draw_y;
                    colour_n = ring_colour_q;
                    plot_n   = drw.draw_plot && on_screen;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_circle_sequencer.sv
// Directed bench for circle_sequencer with a small behavioural circle drawer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_circle_sequencer;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic [7:0] cx, cy, r_base, r_step;
    logic [2:0] ring_count, ring_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic [2:0] colour;
    logic       busy;
    logic       done;

    circle_sequencer_if drw_if ();

    circle_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .cx          (cx),
        .cy          (cy),
        .r_base      (r_base),
        .r_step      (r_step),
        .ring_count  (ring_count),
        .ring_colour (ring_colour),
        .drw         (drw_if),
        .x           (x),
        .y           (y),
        .plot        (plot),
        .colour      (colour),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    // Results gathered by run_sequence for the tests to judge.
    int         seq_clear_plots;
    int         seq_ring_plots;
    int         seq_starts;
    int         seq_order_bad;
    int         seq_colour_bad;
    int         seq_radius_unstable;
    logic       seq_timeout;
    logic [7:0] seq_radii [0:7];
    logic [7:0] seq_cx0, seq_cy0;
    logic [7:0] seq_first_x, seq_last_x;
    logic [6:0] seq_first_y, seq_last_y;
    logic       seq_clip_a, seq_clip_b;
    logic [7:0] seq_clip_x;
    logic [6:0] seq_clip_y;
    logic [2:0] seq_clip_colour;
    logic       inject_glitches;

    // Free-running clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Hard stop in case something wedges beyond every loop bound.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents a request for one cycle; returns on the edge where CLEAR's first pixel is visible.
    task automatic pulse_start(input logic [7:0] a_cx, input logic [7:0] a_cy,
                               input logic [7:0] a_rb, input logic [7:0] a_rs,
                               input logic [2:0] a_n, input logic [2:0] a_col);
        cx          = a_cx;
        cy          = a_cy;
        r_base      = a_rb;
        r_step      = a_rs;
        ring_count  = a_n;
        ring_colour = a_col;
        start       = 1'b1;
        @(negedge CLOCK_50);
        start       = 1'b0;
    endtask

    // Drawer model plus observer: answers each draw_start with one off-screen and
    // one corner pixel, then draw_done 50 cycles later; records what it sees.
    task automatic run_sequence(input int budget);
        int         cnt;
        logic       waiting;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [7:0] held_radius;
        cnt = 0; waiting = 1'b0; ex = 8'd0; ey = 7'd0; held_radius = 8'd0;
        seq_clear_plots = 0; seq_ring_plots = 0; seq_starts = 0;
        seq_order_bad = 0; seq_colour_bad = 0; seq_radius_unstable = 0;
        seq_timeout = 1'b1;
        for (int i = 0; i < 8; i++) seq_radii[i] = 8'd0;
        seq_cx0 = 8'd0; seq_cy0 = 8'd0;
        seq_first_x = 8'hFF; seq_first_y = 7'h7F; seq_last_x = 8'hFF; seq_last_y = 7'h7F;
        seq_clip_a = 1'bx; seq_clip_b = 1'bx; seq_clip_x = 8'd0; seq_clip_y = 7'd0; seq_clip_colour = 3'd0;
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) begin
                seq_timeout = 1'b0;
                break;
            end
            if (plot === 1'b1) begin
                if (seq_starts == 0) begin
                    if (seq_clear_plots == 0) begin
                        seq_first_x = x;
                        seq_first_y = y;
                    end
                    seq_last_x = x;
                    seq_last_y = y;
                    if (x !== ex || y !== ey || busy !== 1'b1) seq_order_bad++;
                    if (colour !== 3'b000) seq_colour_bad++;
                    seq_clear_plots++;
                    if (ex == 8'd159) begin
                        ex = 8'd0;
                        ey = ey + 7'd1;
                    end else begin
                        ex = ex + 8'd1;
                    end
                end else begin
                    seq_ring_plots++;
                end
            end
            if (waiting && cnt == 40 && seq_starts == 1) seq_clip_a = plot;
            if (waiting && cnt == 39 && seq_starts == 1) begin
                seq_clip_b      = plot;
                seq_clip_x      = x;
                seq_clip_y      = y;
                seq_clip_colour = colour;
            end
            if (waiting && drw_if.radius !== held_radius) seq_radius_unstable++;
            if (drw_if.draw_start === 1'b1) begin
                if (seq_starts < 8) seq_radii[seq_starts] = drw_if.radius;
                if (seq_starts == 0) begin
                    seq_cx0 = drw_if.centerx;
                    seq_cy0 = drw_if.centery;
                end
                seq_starts++;
                held_radius = drw_if.radius;
                waiting     = 1'b1;
                cnt         = 51;
            end
            start             = 1'b0;
            drw_if.draw_done  = 1'b0;
            drw_if.draw_plot  = 1'b0;
            drw_if.draw_x     = 8'd0;
            drw_if.draw_y     = 7'd0;
            if (waiting) begin
                cnt--;
                if (cnt == 40) begin
                    drw_if.draw_x = 8'd165; drw_if.draw_y = 7'd10; drw_if.draw_plot = 1'b1;
                end else if (cnt == 39) begin
                    drw_if.draw_x = 8'd159; drw_if.draw_y = 7'd119; drw_if.draw_plot = 1'b1;
                end
                if (inject_glitches && seq_starts == 1 && cnt == 25) start = 1'b1;
                if (cnt == 0) begin
                    drw_if.draw_done = 1'b1;
                    waiting = 1'b0;
                end
            end else if (inject_glitches && seq_starts == 0 && seq_clear_plots == 100) begin
                drw_if.draw_done = 1'b1;
            end
            @(negedge CLOCK_50);
        end
        start = 1'b0;
        drw_if.draw_done = 1'b0;
        drw_if.draw_plot = 1'b0;
    endtask

    // Reset, with start held high alongside it, leaves every output at zero and the block idle.
    task automatic test_reset();
        reset = 1'b1;
        pulse_start(8'd80, 8'd60, 8'd10, 8'd10, 3'd3, 3'b111);
        reset = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (x !== 8'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 0", x); end
        checks++; if (y !== 7'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 0", y); end
        checks++; if (plot !== 1'b0) begin errors++; $display("[TB] FAIL reset_plot: got %b expected 0", plot); end
        checks++; if (colour !== 3'd0) begin errors++; $display("[TB] FAIL reset_colour: got %0d expected 0", colour); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: got busy=%b done=%b expected 0/0", busy, done); end
        checks++; if (drw_if.draw_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_draw_start: got %b expected 0", drw_if.draw_start); end
        checks++; if (drw_if.centerx !== 8'd0 || drw_if.centery !== 8'd0 || drw_if.radius !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_drawer_params: got %0d/%0d/%0d expected 0/0/0", drw_if.centerx, drw_if.centery, drw_if.radius);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored: got busy=%b plot=%b expected 0/0", busy, plot); end
    endtask

    // A zero-ring request only clears the screen, in raster order, then finishes.
    task automatic test_clear_only();
        inject_glitches = 1'b0;
        pulse_start(8'd80, 8'd60, 8'd10, 8'd10, 3'd0, 3'b111);
        run_sequence(25000);
        checks++; if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL clear_timeout: got timeout expected done"); end
        checks++; if (seq_clear_plots != 19200) begin errors++; $display("[TB] FAIL clear_count: got %0d expected 19200", seq_clear_plots); end
        checks++; if (seq_order_bad != 0) begin errors++; $display("[TB] FAIL clear_order: got %0d bad pixels expected 0", seq_order_bad); end
        checks++; if (seq_colour_bad != 0) begin errors++; $display("[TB] FAIL clear_colour: got %0d bad pixels expected 0", seq_colour_bad); end
        checks++; if (seq_first_x !== 8'd0 || seq_first_y !== 7'd0) begin errors++; $display("[TB] FAIL clear_first: got (%0d,%0d) expected (0,0)", seq_first_x, seq_first_y); end
        checks++; if (seq_last_x !== 8'd159 || seq_last_y !== 7'd119) begin errors++; $display("[TB] FAIL clear_last: got (%0d,%0d) expected (159,119)", seq_last_x, seq_last_y); end
        checks++; if (seq_starts != 0) begin errors++; $display("[TB] FAIL clear_no_draw: got %0d draw_start expected 0", seq_starts); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_done: got done=%b busy=%b expected 1/0", done, busy); end
    endtask

    // Three rings 10/20/30 around (80,60); a start during WAIT and a draw_done
    // during CLEAR must change nothing, nor may the inputs changing after acceptance.
    task automatic test_rings();
        inject_glitches = 1'b1;
        pulse_start(8'd80, 8'd60, 8'd10, 8'd10, 3'd3, 3'b011);
        cx = 8'd1; cy = 8'd2; r_base = 8'd99; r_step = 8'd1; ring_count = 3'd7; ring_colour = 3'b111;
        run_sequence(25000);
        inject_glitches = 1'b0;
        checks++; if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rings_timeout: got timeout expected done"); end
        checks++; if (seq_clear_plots != 19200) begin errors++; $display("[TB] FAIL rings_clear_count: got %0d expected 19200", seq_clear_plots); end
        checks++; if (seq_starts != 3) begin errors++; $display("[TB] FAIL rings_count: got %0d expected 3", seq_starts); end
        checks++; if (seq_radii[0] !== 8'd10 || seq_radii[1] !== 8'd20 || seq_radii[2] !== 8'd30) begin
            errors++; $display("[TB] FAIL rings_radii: got %0d,%0d,%0d expected 10,20,30", seq_radii[0], seq_radii[1], seq_radii[2]);
        end
        checks++; if (seq_cx0 !== 8'd80 || seq_cy0 !== 8'd60) begin errors++; $display("[TB] FAIL rings_centre: got (%0d,%0d) expected (80,60)", seq_cx0, seq_cy0); end
        checks++; if (drw_if.centerx !== 8'd80 || drw_if.centery !== 8'd60) begin errors++; $display("[TB] FAIL rings_centre_end: got (%0d,%0d) expected (80,60)", drw_if.centerx, drw_if.centery); end
        checks++; if (seq_radius_unstable != 0) begin errors++; $display("[TB] FAIL rings_radius_stable: got %0d changes expected 0", seq_radius_unstable); end
        checks++; if (seq_ring_plots != 3) begin errors++; $display("[TB] FAIL rings_plots: got %0d expected 3", seq_ring_plots); end
        checks++; if (seq_clip_colour !== 3'b011) begin errors++; $display("[TB] FAIL rings_colour: got %b expected 011", seq_clip_colour); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rings_done: got done=%b busy=%b expected 1/0", done, busy); end
    endtask

    // 200 + k*40: 200 and 240 fit, 280 does not, so only two rings; the drawer's
    // off-screen pixel is clipped and the corner pixel passes.
    task automatic test_overflow_and_clip();
        pulse_start(8'd10, 8'd20, 8'd200, 8'd40, 3'd4, 3'b101);
        run_sequence(25000);
        checks++; if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_timeout: got timeout expected done"); end
        checks++; if (seq_starts != 2) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 2", seq_starts); end
        checks++; if (seq_radii[0] !== 8'd200 || seq_radii[1] !== 8'd240) begin
            errors++; $display("[TB] FAIL ovf_radii: got %0d,%0d expected 200,240", seq_radii[0], seq_radii[1]);
        end
        checks++; if (seq_clip_a !== 1'b0) begin errors++; $display("[TB] FAIL clip_offscreen: got plot=%b expected 0", seq_clip_a); end
        checks++; if (seq_clip_b !== 1'b1) begin errors++; $display("[TB] FAIL clip_corner_plot: got plot=%b expected 1", seq_clip_b); end
        checks++; if (seq_clip_x !== 8'd159 || seq_clip_y !== 7'd119) begin errors++; $display("[TB] FAIL clip_corner_xy: got (%0d,%0d) expected (159,119)", seq_clip_x, seq_clip_y); end
        checks++; if (seq_clip_colour !== 3'b101) begin errors++; $display("[TB] FAIL clip_colour: got %b expected 101", seq_clip_colour); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done: got %b expected 1", done); end
    endtask

    // Reset at clear pixel (40,10) stops everything at once; a new start begins at (0,0).
    task automatic test_reset_mid_clear();
        logic found;
        found = 1'b0;
        pulse_start(8'd33, 8'd44, 8'd5, 8'd5, 3'd2, 3'b001);
        for (int c = 0; c < 3000; c++) begin
            if (plot === 1'b1 && x === 8'd40 && y === 7'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL midclear_reach: got not found expected pixel (40,10)"); end
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midclear_status: got plot=%b busy=%b done=%b expected 0/0/0", plot, busy, done); end
        checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("[TB] FAIL midclear_xy: got (%0d,%0d) expected (0,0)", x, y); end
        checks++; if (drw_if.centerx !== 8'd0 || drw_if.radius !== 8'd0) begin errors++; $display("[TB] FAIL midclear_params: got cx=%0d r=%0d expected 0/0", drw_if.centerx, drw_if.radius); end
        reset = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midclear_idle: got plot=%b busy=%b expected 0/0", plot, busy); end
        pulse_start(8'd33, 8'd44, 8'd5, 8'd5, 3'd2, 3'b001);
        checks++; if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd0) begin errors++; $display("[TB] FAIL restart_first: got plot=%b (%0d,%0d) expected 1 (0,0)", plot, x, y); end
        @(negedge CLOCK_50);
        checks++; if (plot !== 1'b1 || x !== 8'd1 || y !== 7'd0) begin errors++; $display("[TB] FAIL restart_second: got plot=%b (%0d,%0d) expected 1 (1,0)", plot, x, y); end
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    // Test sequence.
    initial begin
        reset = 1'b1; start = 1'b0;
        cx = 8'd0; cy = 8'd0; r_base = 8'd0; r_step = 8'd0; ring_count = 3'd0; ring_colour = 3'd0;
        drw_if.draw_done = 1'b0; drw_if.draw_x = 8'd0; drw_if.draw_y = 7'd0; drw_if.draw_plot = 1'b0;
        inject_glitches = 1'b0;
        @(negedge CLOCK_50);
        $display("[TB] reset");
        test_reset();
        $display("[TB] clear only");
        test_clear_only();
        $display("[TB] three rings with ignored start/draw_done");
        test_rings();
        $display("[TB] radius overflow and clipping");
        test_overflow_and_clip();
        $display("[TB] reset during clear");
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
